// File: rtl/esram_ahb_master_if.sv
// esram_ahb_master_if: AHB-Lite single-master bus between the eSRAM master and its slave.
interface esram_ahb_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/esram_ahb_master.sv
// esram_ahb_master: single-beat byte-wide AHB-Lite master with data-phase timeout.
// Bus outputs are registered from the next-state so they change cleanly on the clock edge.
module esram_ahb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ahb_addr,
    input  logic [7:0]  ahb_data_out,
    input  logic        ahb_write,
    input  logic        ahb_read,
    output logic        ahb_busy,
    output logic        ahb_valid,
    output logic [7:0]  ahb_rdata,
    output logic        ahb_err,
    esram_ahb_master_if.master ahb
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        fail;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        fail    = !ahb.HREADY || ahb.HRESP;
        if (state_q == IDLE && (ahb_write || ahb_read)) begin
            state_d = ADDR;
            addr_d  = ahb_addr;
            wdata_d = ahb_data_out;
            dir_d   = ahb_write;
        end
        if (state_q == ADDR && ahb.HREADY) begin
            state_d = DATA;
            cnt_d   = '0;
        end
        if (state_q == DATA) begin
            // Completion and timeout share one exit; a timeout is just a failed completion
            if (ahb.HREADY || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                err_d   = fail;
                valid_d = !dir_q;
                rdata_d = dir_q ? rdata_q : fail ? 8'hFF : ahb.HRDATA[{addr_q[1:0], 3'b000} +: 8];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        busy_d   = state_d != IDLE;
        htrans_d = state_d == ADDR ? 2'b10 : 2'b00;
        hwrite_d = state_d == ADDR && dir_d;
        hwdata_d = state_d == DATA && dir_d ? {4{wdata_d}} : 32'h0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            htrans_q <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
        end
    end
    assign ahb_busy   = busy_q;
    assign ahb_valid  = valid_q;
    assign ahb_err    = err_q;
    assign ahb_rdata  = rdata_q;
    assign ahb.HADDR  = addr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HWDATA = hwdata_q;
    assign ahb.HSIZE  = 3'b000;
    assign ahb.HBURST = 3'b000;
endmodule

// File: tb/tb_esram_ahb_master.sv
// tb_esram_ahb_master: directed and randomized transactions checked against a cycle-count model.
module tb_esram_ahb_master;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ahb_addr = '0;
    logic [7:0]  ahb_data_out = '0;
    logic        ahb_write = 1'b0;
    logic        ahb_read = 1'b0;
    logic        ahb_busy, ahb_valid, ahb_err;
    logic [7:0]  ahb_rdata;
    logic [7:0]  exp_rdata = '0;
    int          checks = 0;
    int          errors = 0;
    esram_ahb_master_if bus();
    esram_ahb_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .ahb_addr(ahb_addr), .ahb_data_out(ahb_data_out),
        .ahb_write(ahb_write), .ahb_read(ahb_read), .ahb_busy(ahb_busy), .ahb_valid(ahb_valid),
        .ahb_rdata(ahb_rdata), .ahb_err(ahb_err), .ahb(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_reset_state();
        check("rst_busy", ahb_busy, 0);
        check("rst_valid", ahb_valid, 0);
        check("rst_err", ahb_err, 0);
        check("rst_rdata", ahb_rdata, 0);
        check("rst_haddr", bus.HADDR, 0);
        check("rst_htrans", bus.HTRANS, 0);
        check("rst_hwrite", bus.HWRITE, 0);
        check("rst_hwdata", bus.HWDATA, 0);
        check("rst_hsize", bus.HSIZE, 0);
        check("rst_hburst", bus.HBURST, 0);
    endtask
    // Called at a falling edge; the command is sampled on the next rising edge (cycle 0).
    // aw/dw are address/data-phase wait states; extra>0 injects a stray command in that cycle.
    task automatic do_txn(input logic w, input logic r, input logic [31:0] a, input logic [7:0] d,
                          input int aw, input int dw, input logic resp, input logic [31:0] rd,
                          input int extra);
        logic is_wr = w;
        logic tmo = dw >= T;
        logic fail = tmo || resp;
        int   c = tmo ? aw + 1 + T : aw + 2 + dw;
        ahb_write = w; ahb_read = r; ahb_addr = a; ahb_data_out = d;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = rd;
        for (int k = 1; k <= c + 2; k++) begin
            @(negedge clk);
            if (k == c + 1 && !is_wr) exp_rdata = fail ? 8'hFF : rd[8*a[1:0] +: 8];
            check("busy", ahb_busy, k <= c);
            check("valid", ahb_valid, k == c + 1 && !is_wr);
            check("err", ahb_err, k == c + 1 && fail);
            check("rdata", ahb_rdata, exp_rdata);
            check("htrans", bus.HTRANS, k <= aw + 1 ? 2'b10 : 2'b00);
            check("hwrite", bus.HWRITE, k <= aw + 1 && is_wr);
            check("hwdata", bus.HWDATA, (k >= aw + 2 && k <= c && is_wr) ? {4{d}} : 32'h0);
            if (k <= aw + 1) check("haddr", bus.HADDR, a);
            ahb_write = 1'b0; ahb_read = 1'b0;
            if (k == extra && extra <= c) begin
                ahb_write = 1'($urandom_range(0, 1));
                ahb_read = !ahb_write;
                ahb_addr = $urandom;
                ahb_data_out = 8'($urandom);
            end
            bus.HREADY = k <= aw ? 1'b0 : k == aw + 1 ? 1'b1 : k < aw + 2 + dw ? 1'b0 : 1'b1;
            bus.HRESP = k >= aw + 2 ? resp : 1'b0;
        end
    endtask
    task automatic reset_mid(input logic [31:0] a);
        ahb_read = 1'b1; ahb_addr = a; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        @(negedge clk);
        ahb_read = 1'b0;
        @(negedge clk);
        bus.HREADY = 1'b0;
        @(negedge clk);
        check("mid_busy", ahb_busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
        bus.HREADY = 1'b1;
    endtask
    initial begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        do_txn(0, 1, 32'h20000005, 8'h00, 0, 0, 0, 32'hA1B2C3D4, 0);
        do_txn(1, 0, 32'h20000010, 8'h5A, 0, 0, 0, 32'hDEADBEEF, 0);
        do_txn(0, 1, 32'h20000006, 8'h00, 0, 3, 0, 32'h11223344, 2);
        do_txn(0, 1, 32'h20000003, 8'h00, 0, 1, 1, 32'h55667788, 0);
        do_txn(0, 1, 32'h20000000, 8'h00, 0, 10, 0, 32'h99AABBCC, 0);
        do_txn(1, 0, 32'h20000020, 8'hC3, 1, 2, 0, 32'h0, 0);
        do_txn(1, 1, 32'h20000031, 8'h7E, 0, 0, 0, 32'h01020304, 0);
        reset_mid(32'h20000040);
        do_txn(0, 1, 32'h20000042, 8'h00, 0, 0, 0, 32'hCAFEF00D, 0);
        for (int i = 0; i < 80; i++) begin
            int kind = $urandom_range(0, 2);
            do_txn(kind != 1, kind != 0, $urandom, 8'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 5), $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 8));
        end
        reset_mid(32'h20000050);
        do_txn(1, 0, 32'h20000053, 8'hA5, 0, 0, 0, 32'h0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
